// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//
// Multi-channel input debouncer. Each raw asynchronous input goes through a
// two-flop synchroniser. A new level is accepted only after the synchronised
// value has differed from the accepted level for STABLE_COUNT consecutive
// time-base ticks. Each channel reports its accepted level, one-cycle rise and
// fall pulses, and an optional auto-repeat pulse while the level is held high.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset_       asynchronous active-low reset; clears all state
//   tick_i       time-base enable for the stability and repeat counters
//   raw_i        raw asynchronous inputs, one bit per channel
//   debounced_o  accepted steady level per channel
//   rise_o       one-cycle pulse in the first cycle of a new high level
//   fall_o       one-cycle pulse in the first cycle of a new low level
//   repeat_o     one-cycle auto-repeat pulse while debounced_o is high
//   any_change_o high in the same cycle as any rise_o or fall_o bit
// -----------------------------------------------------------------------------
module multi_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int STABLE_COUNT  = 255,
  parameter int REPEAT_EN     = 0,
  parameter int RPT_WIDTH     = 12,
  parameter int REPEAT_DELAY  = 2000,
  parameter int REPEAT_PERIOD = 500
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                tick_i,
  input  logic [CHANNELS-1:0] raw_i,
  output logic [CHANNELS-1:0] debounced_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] repeat_o,
  output logic                any_change_o
);

  // Terminal values: counters compare against N-1 so that acceptance (or a
  // repeat pulse) happens on the N-th qualifying tick and the counter never
  // needs to hold N itself.
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [RPT_WIDTH-1:0] DELAY_LAST  = RPT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [RPT_WIDTH-1:0] PERIOD_LAST = RPT_WIDTH'(REPEAT_PERIOD - 1);
  localparam bit                   RPT_ON      = (REPEAT_EN != 0);

  logic [CHANNELS-1:0]  s1_q, s2_q;
  logic [CHANNELS-1:0]  deb_q, deb_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic [CHANNELS-1:0]  rpt_q, rpt_d;
  logic                 any_q, any_d;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [RPT_WIDTH-1:0] tmr_q [CHANNELS];
  logic [RPT_WIDTH-1:0] tmr_d [CHANNELS];
  // Per channel: 0 = waiting for the initial delay, 1 = in the periodic phase.
  logic [CHANNELS-1:0]  period_q, period_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    deb_d    = deb_q;
    rise_d   = '0;
    fall_d   = '0;
    rpt_d    = '0;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    period_d = period_q;

    for (int i = 0; i < CHANNELS; i++) begin
      // Stability counter: any return to the accepted level clears progress,
      // even on cycles without a tick.
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_i) begin
        if (cnt_q[i] == STABLE_LAST) begin
          cnt_d[i]  = '0;
          deb_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end

      // Repeat timer: an accepted edge in either direction restarts the
      // delay phase and suppresses any pulse on that edge, so a repeat can
      // never coincide with rise or fall.
      if (rise_d[i] || fall_d[i]) begin
        tmr_d[i]    = '0;
        period_d[i] = 1'b0;
      end else if (deb_q[i] && tick_i) begin
        if (tmr_q[i] == (period_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          tmr_d[i]    = '0;
          period_d[i] = 1'b1;
          rpt_d[i]    = RPT_ON;
        end else begin
          tmr_d[i] = tmr_q[i] + RPT_WIDTH'(1);
        end
      end
    end

    any_d = |{rise_d, fall_d};
  end

  // NOTE: the per-channel counter arrays are individual flops, not RAM, so
  // they are cleared by reset along with everything else; a reset mid-count
  // must discard progress.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      rpt_q    <= '0;
      any_q    <= 1'b0;
      cnt_q    <= '{default: '0};
      tmr_q    <= '{default: '0};
      period_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, which is what turns s1_q -> s2_q into two stages.
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rpt_q    <= rpt_d;
      any_q    <= any_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      period_q <= period_d;
    end
  end

  assign debounced_o  = deb_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign repeat_o     = rpt_q;
  assign any_change_o = any_q;

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised, multi-channel successor to the single-bit debouncer. It synchronises N raw asynchronous inputs (buttons, joystick lines) and accepts a new level only after it has held for a programmable number of time-base ticks. Per channel it outputs the debounced level, one-cycle rise and fall pulses, and an optional auto-repeat pulse while the input is held. It sits between the board inputs and consumers such as the code-sequence acceptor, which then need no edge detectors of their own.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
CNT_WIDTH, 8, width of each stability counter
STABLE_COUNT, 255, consecutive ticks a new level must hold before acceptance (1 .. 2^CNT_WIDTH-1)
REPEAT_EN, 0, 1 enables auto-repeat pulses; 0 forces repeat outputs to 0
RPT_WIDTH, 12, width of each repeat timer
REPEAT_DELAY, 2000, ticks from rise to first repeat pulse (1 .. 2^RPT_WIDTH-1)
REPEAT_PERIOD, 500, ticks between subsequent repeat pulses (1 .. 2^RPT_WIDTH-1)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_  input  1  asynchronous active-low reset; clears all state immediately
tick  input  1  time-base enable for the counters; tie to 1 for per-clock counting
raw  input  CHANNELS  raw asynchronous inputs
debounced  output  CHANNELS  accepted steady level per channel
rise  output  CHANNELS  one-clk pulse when debounced[i] goes 0->1
fall  output  CHANNELS  one-clk pulse when debounced[i] goes 1->0
repeat  output  CHANNELS  one-clk auto-repeat pulse while debounced[i] is held high
any_change  output  1  registered OR of all rise and fall bits

Behaviour:
- Reset (async, reset_=0): sync flops, counters, repeat timers, debounced, rise, fall, repeat and any_change are all 0. Reset mid-count discards progress. A raw input held high through reset release produces a normal rise after acceptance.
- Synchroniser: per channel, raw -> s1 -> s2 on every clk, independent of tick.
- Stability counter, evaluated every clk edge, with priority in this order:
  - s2==debounced: counter <= 0. A glitch clears progress even on non-tick cycles.
  - s2!=debounced, tick=1, counter==STABLE_COUNT-1: debounced <= s2, counter <= 0.
  - s2!=debounced, tick=1, otherwise: counter <= counter+1.
  - s2!=debounced, tick=0: counter holds.
- Latency with tick=1: raw stable and sampled at edge 0 -> debounced changes at edge STABLE_COUNT+1. Any s2 mismatch-return restarts the count.
- rise/fall:
  - Registered at the same edge as the debounced update.
  - High for exactly one clk cycle, coinciding with the first cycle of the new level.
  - rise and fall are never both high on one channel.
- any_change: registered with rise/fall, so it is high in the same cycle as any rise or fall bit.
- Repeat, when REPEAT_EN=1, per channel:
  - Timer cleared at the edge debounced goes high.
  - While debounced=1, the timer increments on tick edges.
  - When the timer reaches REPEAT_DELAY on a tick edge: repeat pulses for one clk and the timer reloads to 0; the target then becomes REPEAT_PERIOD.
  - Subsequent pulses occur every REPEAT_PERIOD ticks.
  - The fall edge clears the timer and restores the target to REPEAT_DELAY; no pulse is emitted on fall.
  - repeat never coincides with rise.
- Repeat, when REPEAT_EN=0: the timers may be optimised out and repeat is constant 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses.
- Counters never wrap: acceptance at STABLE_COUNT-1 always precedes overflow.

Test Plan:
- Reset, then raw=4'b0001 held with tick=1, STABLE_COUNT=4: debounced[0]=1 at edge 5; rise[0] high for exactly one cycle at edge 5; any_change high in the same cycle; other channels stay 0.
- Glitch: raw[1] high for 3 cycles then low, STABLE_COUNT=4: debounced[1], rise[1] and fall[1] stay 0 throughout.
- Tick gating: tick pulsed once every 4 clks, STABLE_COUNT=3, raw[2] rises and holds: debounced[2] updates on the 3rd tick edge after s2 changes, not earlier.
- Auto-repeat: REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, tick=1, raw[3] held high: first repeat pulse 10 edges after rise, then every 3 edges. After release: fall pulse, no further repeat pulses.
- Simultaneous release: raw 4'b1111 -> 4'b0000 after acceptance: fall=4'b1111 in one cycle, any_change=1, debounced=0.
- Reset mid-operation: assert reset_ partway through a count: all outputs 0 immediately. On release with raw still high, rise occurs STABLE_COUNT+1 edges after release.
